uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-level round-robin arbiter that lets up to NUM_REQ on-chip requesters share a single UART byte transmitter. Each requester presents a byte stream with a last-byte marker. The arbiter grants one requester at a time and holds the grant until that requester's last byte has been handed to the transmitter. It paces byte hand-off against the transmitter's busy flag and sits between the command/response logic and the UART TX serializer.

## Interface

Parameters:
- NUM_REQ, default 4: number of requesters; legal range 1..16.
- TIMEOUT_CYCLES, default 100_000: stall limit; used only when UART_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk, input, 1: single clock; all logic is on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_req_valid, input, NUM_REQ: bit k means requester k presents a byte.
- i_req_data, input, 8*NUM_REQ: requester k's byte on bits [8k+7:8k].
- i_req_last, input, NUM_REQ: requester k's byte is the final byte of its packet.
- o_req_ready, output, NUM_REQ: byte k accepted this cycle; the transfer occurs when valid and ready are both high.
- i_tx_busy, input, 1: transmitter is serializing a byte.
- o_tx_data, output, 8: byte to transmit.
- o_tx_en, output, 1: single-cycle strobe to load o_tx_data into the transmitter.
- o_grant, output, NUM_REQ: one-hot current owner; all zero when idle.
- o_timeout, output, 1: single-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

## Operation

- Reset values:
  - o_grant = 0, o_req_ready = 0, o_tx_en = 0, o_tx_data = 8'h00, o_timeout = 0, state = IDLE.
  - The round-robin pointer is set so requester 0 has highest priority.
- States:
  - IDLE: if any i_req_valid bit is set, select the first set bit searching upward (with wrap) from pointer+1, register o_grant, and go to GRANT. Otherwise stay in IDLE.
  - GRANT (owner g): o_req_ready[g] is driven combinationally as i_req_valid[g] & !i_tx_busy; all other ready bits are 0. On transfer, register o_tx_data = i_req_data[g] and o_tx_en = 1, latch last = i_req_last[g], and go to GUARD.
  - GUARD: o_tx_en is high for exactly this cycle and i_tx_busy is ignored. If the latched last is 1: clear o_grant, set pointer = g, go to IDLE. Otherwise return to GRANT.
- Rules:
  - Requests from non-owners are ignored and not queued; they are re-evaluated in IDLE.
  - The owner may drop i_req_valid mid-packet. The grant is held: without the macro, indefinitely; with the macro, see Configuration.
  - i_req_last is sampled only on a transfer cycle.
  - The transmitter must raise i_tx_busy no later than the cycle after it samples o_tx_en.
  - A reset mid-packet abandons the packet: no further bytes and no o_tx_en.

## Timing

- Request in IDLE at cycle 0 gives o_grant at cycle 1. Ready/transfer can occur at cycle 1, and o_tx_en at cycle 2.
- Byte-to-byte: the next transfer is possible no earlier than 2 cycles after the previous one, and in practice is gated by i_tx_busy.
- Packet-to-packet: the last byte's GUARD cycle is followed by IDLE (1 cycle), then the new grant. This gives a minimum 2-cycle gap between the last o_tx_en and the next o_grant change.
- Fairness: with all NUM_REQ requesting continuously, each requester is granted exactly once per NUM_REQ packets.
- o_req_ready has a combinational path from i_req_valid and i_tx_busy. All other outputs are registered.

## Configuration

- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in GRANT while i_req_valid[g] = 0. It clears on any cycle where valid is high and on every state change.
  - Cycles with valid high and i_tx_busy high do not count.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter pulses o_timeout for 1 cycle, clears o_grant, sets pointer = g, and goes to IDLE. The remainder of the packet is lost.
- UART_ARB_TIMEOUT_EN undefined: no counter is built, o_timeout is tied to 0, and a stalled owner holds the grant forever.

## Test plan

- Reset, then requester 2 sends a 3-byte packet 8'hA1, A2, A3 (last on A3) with the transmitter held busy for 10 cycles per byte. Expected: o_grant = 4'b0100, three o_tx_en pulses carrying A1, A2, A3 in order each ≥10 cycles apart, then o_grant = 0.
- All 4 requesters hold 1-byte packets from reset. Expected grant order 0, 1, 2, 3, 0, and no two o_tx_en pulses closer than 2 cycles.
- Requester 1 is mid-packet while requester 0 raises valid. Expected: requester 0 stays unserved until requester 1's last byte completes, then is granted.
- i_tx_busy is held high for 50 cycles while the owner is valid. Expected: o_req_ready stays 0, there is no o_tx_en, and the byte transfers on the first cycle busy is low.
- i_rst asserted after 1 of 3 bytes. Expected: all outputs return to reset values within the reset cycle, no further o_tx_en, and requester 0 has priority afterwards.
- Macro defined with TIMEOUT_CYCLES = 20: the owner drops valid mid-packet. Expected: o_timeout pulses after 20 cycles, o_grant clears, and the next requester is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter sharing one UART byte transmitter
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic                   i_tx_busy,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_en,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_owner;
    logic                r_last;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_tx_data;
    logic                r_tx_en;

    logic [7:0]          w_data [NUM_REQ];
    logic [IW-1:0]       w_idx;
    logic [IW-1:0]       w_sel;
    logic                w_found;
    logic                w_own_valid;
    logic                w_xfer;
    logic                w_timeout;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_data[k] = i_req_data[8*k +: 8];
        end
    end

    // First valid requester strictly after the last owner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_own_valid = i_req_valid[r_owner];
    assign w_xfer      = (r_state == GRANT) && w_own_valid && !i_tx_busy;
    assign o_req_ready = w_xfer ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_tx_data   = r_tx_data;
    assign o_tx_en     = r_tx_en;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] r_stall_cnt;
    logic        r_timeout;

    assign w_timeout = (r_state == GRANT) && !w_own_valid &&
                       (r_stall_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (r_state != GRANT || w_own_valid || w_timeout) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= IW'(NUM_REQ - 1);
            r_owner   <= '0;
            r_last    <= 1'b0;
            r_grant   <= '0;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_tx_en   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= NUM_REQ'(1) << w_sel;
                        r_owner <= w_sel;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_tx_data <= w_data[r_owner];
                        r_tx_en   <= 1'b1;
                        r_last    <= i_req_last[r_owner];
                        r_state   <= GUARD;
                    end else if (w_timeout) begin
`ifdef UART_ARB_TIMEOUT_EN
                        r_timeout <= 1'b1;
`endif
                        r_grant   <= '0;
                        r_ptr     <= r_owner;
                        r_state   <= IDLE;
                    end
                end
                GUARD: begin
                    // Busy is not trusted here: the transmitter may not have raised it yet.
                    if (r_last) begin
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                        r_state <= IDLE;
                    end else begin
                        r_state <= GRANT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
